psum_addr_gen: RTL and testbench
================================

Name: psum_addr_gen

Overview:
- Downstream of the psum index generator in the NoC controller.
- Converts each (psum_index, channel, row, col) tuple, presented while the generator's busy is high, into a linear GLB psum address plus a bank select.
- Buffers addresses in a small FIFO toward the GLB write port, and back-pressures the generator through its await input.
- Forwards the generator's done as a single drained-done pulse once every queued address has been consumed.

Parameters:
- F_WIDTH, 6, col index / F dimension width
- m_WIDTH, 8, channel index width
- n_WIDTH, 3, psum (bank) index width
- e_WIDTH, 8, row index / E dimension width
- ADDR_WIDTH, 16, GLB psum address width
- DEPTH, 4, output FIFO entries (power of 2, >=4)

Ports:
- clk  in  1  clock; all state updates on negedge, matching the index generator
- reset  in  1  reset, asynchronous, active-high
- base_addr  in  ADDR_WIDTH  GLB psum region base; static during a pass
- E  in  e_WIDTH  rows per channel
- F  in  F_WIDTH  columns per row
- idx_valid  in  1  tuple valid; tied to generator busy
- psum_index  in  n_WIDTH  bank select
- channel_index  in  m_WIDTH  output channel
- row_index  in  e_WIDTH  output row
- col_index  in  F_WIDTH  output column
- gen_done  in  1  generator done pulse
- await  out  1  back-pressure to generator
- addr_valid  out  1  FIFO head valid
- addr_ready  in  1  GLB accepts head
- addr  out  ADDR_WIDTH  head address
- bank  out  n_WIDTH  head bank
- done  out  1  one-cycle drained-done pulse
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset: FIFO empty; pipeline valids 0; state IDLE; await=0, addr_valid=0, addr=0, bank=0, done=0, busy=0.
- Address formula: addr = base_addr + (channel_index*E + row_index)*F + col_index.
  - All arithmetic is zero-extended to ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH.
- Pipeline, two stages:
  - S1 registers lin1 = channel*E + row, plus col and bank.
  - S2 registers lin1*F + col + base_addr and pushes it into the FIFO in the same edge.
  - Latency from an idx_valid sample to addr_valid on an empty FIFO is 3 edges.
- Capture: a tuple is captured on an edge where idx_valid=1 and await=0. A tuple presented while await=1 is ignored; the generator holds while await=1.
- await: combinational, = (fifo_count + v1 + v2) >= DEPTH.
  - The count is conservative and ignores a same-cycle pop.
  - Consequence: the FIFO can never overflow.
- Pop: occurs when addr_valid && addr_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - A push to an empty FIFO with a simultaneous pop is impossible, since addr_valid=0.
- addr and bank are driven from the FIFO head. When the FIFO is empty they hold their last value.
- FSM:
  - IDLE -> RUN on the first captured tuple.
  - RUN -> DRAIN on gen_done.
  - DRAIN -> IDLE when v1=v2=0 and the FIFO is empty; done pulses 1 cycle on that transition.
  - gen_done in IDLE, i.e. an empty pass, pulses done the next edge.
  - gen_done arriving on the same edge as a capture still captures the tuple, then goes to DRAIN.
- Tuples arriving in DRAIN are captured normally, and DRAIN waits for them.
- Reset mid-operation discards all queued addresses; no done is issued.

Optional Feature:
- Macro: PSUM_ADDR_CHECK_EN.
- When defined:
  - Adds output err (1 bit, sticky) and input err_clr.
  - err sets on capture if row_index>=E, col_index>=F, or the address computation overflows ADDR_WIDTH.
  - The offending tuple is still queued.
  - err clears on err_clr or reset.
- When undefined: the err/err_clr ports and their logic are absent, and the module has no range checking.

Decomposition:
- Package psum_addr_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - localparam PIPE_STAGES=2;
  - function calc_lin(channel, row, E).
- One sub-module, psum_addr_fifo:
  - synchronous FIFO of {bank, addr}, parameterised by DEPTH and width;
  - exposes count, empty, push, pop.
- The parent module holds the pipeline, await logic and FSM.

Test Plan:
- Address computation: base=0x100, E=4, F=8, ch=2, row=3, col=5, bank=1 -> addr=0x100+(2*4+3)*8+5=0x15D, bank=1, addr_valid 3 edges after capture.
- Back-pressure: addr_ready=0, stream 6 tuples -> await rises when 4 entries are outstanding, exactly 4 captured, no loss or duplicate; release ready -> order preserved.
- Simultaneous push/pop: addr_ready=1 with continuous idx_valid -> await stays 0 beyond warm-up, one address per edge, count stable.
- Done sequencing: gen_done with 3 entries queued and ready toggling -> done pulses exactly once, one cycle after the last pop; busy falls with it.
- Wrap-around: base=0xFFF0, linear offset 0x20 -> addr=0x0010; with PSUM_ADDR_CHECK_EN, err=1.
- Reset mid-DRAIN: 2 queued, assert reset -> addr_valid=0, await=0, done never pulses, state IDLE.

Source files
------------

// File: rtl/psum_addr_pkg.sv
// psum_addr_pkg
//   Shared definitions for the psum address generator:
//     state_e      - controller states (IDLE / RUN / DRAIN)
//     PIPE_STAGES  - number of address pipeline stages ahead of the FIFO
//     CALC_W       - working width of the linear-index helper
//     calc_lin     - channel * E + row, the first half of the address formula
package psum_addr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int PIPE_STAGES = 2;
    localparam int CALC_W      = 32;

    function automatic logic [CALC_W-1:0] calc_lin(
        input logic [CALC_W-1:0] channel,
        input logic [CALC_W-1:0] row,
        input logic [CALC_W-1:0] e
    );
        return channel * e + row;
    endfunction

endpackage

// File: rtl/psum_addr_fifo.sv
// psum_addr_fifo
//   Small synchronous FIFO carrying {bank, addr} entries toward the GLB
//   write port. State advances on the falling clock edge.
//   Ports:
//     clk, reset        - clock (negedge active), async active-high reset
//     push_i, wdata_i   - write strobe and entry
//     pop_i             - remove head entry
//     rdata_o           - head entry (undefined content when empty)
//     count_o, empty_o  - occupancy and empty flag
module psum_addr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (PTR_W + 1)'(1);
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/psum_addr_gen.sv
// psum_addr_gen
//   Turns (psum_index, channel, row, col) tuples from the psum index
//   generator into GLB psum addresses:
//       addr = base_addr + (channel*E + row)*F + col   (mod 2^ADDR_WIDTH)
//   Two pipeline stages feed a small FIFO toward the GLB write port; await
//   holds the generator when the FIFO plus in-flight stages could fill it.
//   The generator's done is forwarded as one drained-done pulse once every
//   queued address has been consumed. All state changes on the falling edge.
//   Ports:
//     clk, reset                 - clock (negedge active), async active-high reset
//     base_addr, E, F            - pass configuration, static during a pass
//     idx_valid + index fields   - incoming tuple (idx_valid = generator busy)
//     gen_done                   - generator done pulse
//     await                      - back-pressure to the generator
//     addr_valid/addr_ready      - FIFO head handshake; addr, bank = head entry
//     done                       - one-cycle drained-done pulse
//     busy                       - high in RUN or DRAIN
//   Optional build macro PSUM_ADDR_CHECK_EN adds err (sticky) / err_clr:
//     err sets when a captured tuple has row>=E, col>=F, or its address
//     overflows ADDR_WIDTH; the tuple is queued regardless.
module psum_addr_gen
    import psum_addr_pkg::*;
#(
    parameter int F_WIDTH    = 6,
    parameter int m_WIDTH    = 8,
    parameter int n_WIDTH    = 3,
    parameter int e_WIDTH    = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [e_WIDTH-1:0]    E,
    input  logic [F_WIDTH-1:0]    F,
    input  logic                  idx_valid,
    input  logic [n_WIDTH-1:0]    psum_index,
    input  logic [m_WIDTH-1:0]    channel_index,
    input  logic [e_WIDTH-1:0]    row_index,
    input  logic [F_WIDTH-1:0]    col_index,
    input  logic                  gen_done,
`ifdef PSUM_ADDR_CHECK_EN
    input  logic                  err_clr,
    output logic                  err,
`endif
    output logic                  await,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [n_WIDTH-1:0]    bank,
    output logic                  done,
    output logic                  busy
);
    localparam int ENT_W = n_WIDTH + ADDR_WIDTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(DEPTH + PIPE_STAGES + 1);

    logic                  capture;
    logic                  drained;
    logic                  pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [ENT_W-1:0]      fifo_head;

    logic                  v1_q, v2_q;
    logic [CALC_W-1:0]     lin1_d, lin1_q;
    logic [F_WIDTH-1:0]    col1_q;
    logic [n_WIDTH-1:0]    bank1_q;
    logic [ADDR_WIDTH-1:0] addr2_d, addr2_q;
    logic [n_WIDTH-1:0]    bank2_q;
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [n_WIDTH-1:0]    hold_bank_q;

    state_e                state_q;
    logic                  done_q, busy_q;

    // Conservative occupancy: a pop on this same edge is not credited.
    assign await   = (OUT_W'(fifo_count) + OUT_W'(v1_q) + OUT_W'(v2_q)) >= OUT_W'(DEPTH);
    assign capture = idx_valid && !await;
    assign drained = !v1_q && !v2_q && fifo_empty && !capture;

    // ---- stage 1: channel*E + row ----
    assign lin1_d = calc_lin(CALC_W'(channel_index), CALC_W'(row_index), CALC_W'(E));

    // ---- stage 2: lin1*F + col + base ----
`ifdef PSUM_ADDR_CHECK_EN
    localparam int WIDE_W = 2 * CALC_W;
    logic [WIDE_W-1:0] sum2_full;
    logic              ovf2;
    logic              range_bad;
    logic              err_q;

    assign sum2_full = WIDE_W'(lin1_q) * WIDE_W'(F) + WIDE_W'(col1_q) + WIDE_W'(base_addr);
    assign addr2_d   = ADDR_WIDTH'(sum2_full);
    assign ovf2      = (sum2_full >> ADDR_WIDTH) != '0;
    assign range_bad = (row_index >= E) || (col_index >= F);

    always_ff @(negedge clk or posedge reset) begin
        if (reset)                                         err_q <= 1'b0;
        else if ((capture && range_bad) || (v1_q && ovf2)) err_q <= 1'b1;
        else if (err_clr)                                  err_q <= 1'b0;
    end
    assign err = err_q;
`else
    assign addr2_d = ADDR_WIDTH'(lin1_q * CALC_W'(F) + CALC_W'(col1_q) + CALC_W'(base_addr));
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= capture;
            v2_q <= v1_q;
        end
    end

    always_ff @(negedge clk) begin
        if (capture) begin
            lin1_q  <= lin1_d;
            col1_q  <= col_index;
            bank1_q <= psum_index;
        end
        if (v1_q) begin
            addr2_q <= addr2_d;
            bank2_q <= bank1_q;
        end
    end

    // ---- stage 3: FIFO toward the GLB write port ----
    assign addr_valid = !fifo_empty;
    assign pop        = addr_valid && addr_ready;

    psum_addr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (v2_q),
        .pop_i   (pop),
        .wdata_i ({bank2_q, addr2_q}),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // The last consumed head is kept so addr/bank stay put while empty.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            hold_addr_q <= '0;
            hold_bank_q <= '0;
        end else if (pop) begin
            hold_addr_q <= fifo_head[ADDR_WIDTH-1:0];
            hold_bank_q <= fifo_head[ENT_W-1:ADDR_WIDTH];
        end
    end

    assign addr = fifo_empty ? hold_addr_q : fifo_head[ADDR_WIDTH-1:0];
    assign bank = fifo_empty ? hold_bank_q : fifo_head[ENT_W-1:ADDR_WIDTH];

    // Controller. A capture on the drain-check edge keeps DRAIN alive so
    // that tuple is flushed before done is issued.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q <= gen_done ? DRAIN : RUN;
                        busy_q  <= 1'b1;
                    end else if (gen_done) begin
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (gen_done) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_psum_addr_gen.sv
module tb_psum_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] base_addr;
    logic [7:0]  E;
    logic [5:0]  F;
    logic        idx_valid;
    logic [2:0]  psum_index;
    logic [7:0]  channel_index;
    logic [7:0]  row_index;
    logic [5:0]  col_index;
    logic        gen_done;
    logic        await;
    logic        addr_valid;
    logic        addr_ready;
    logic [15:0] addr;
    logic [2:0]  bank;
    logic        done;
    logic        busy;
`ifdef PSUM_ADDR_CHECK_EN
    logic        err;
    logic        err_clr;
`endif

    int checks   = 0;
    int errors   = 0;
    int pops     = 0;
    int done_cnt = 0;
    logic [18:0] exp_q [$];

    psum_addr_gen dut (
        .clk           (clk),
        .reset         (reset),
        .base_addr     (base_addr),
        .E             (E),
        .F             (F),
        .idx_valid     (idx_valid),
        .psum_index    (psum_index),
        .channel_index (channel_index),
        .row_index     (row_index),
        .col_index     (col_index),
        .gen_done      (gen_done),
`ifdef PSUM_ADDR_CHECK_EN
        .err_clr       (err_clr),
        .err           (err),
`endif
        .await         (await),
        .addr_valid    (addr_valid),
        .addr_ready    (addr_ready),
        .addr          (addr),
        .bank          (bank),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Monitor: DUT acts on the falling edge, so the rising edge sees stable
    // outputs and the inputs the next falling edge will use.
    always @(posedge clk) begin
        if (addr_valid && addr_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got addr=0x%04h bank=%0d, required no entry", addr, bank);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if (addr !== e[15:0] || bank !== e[18:16]) begin
                    errors++;
                    $display("FAIL pop_entry: got addr=0x%04h bank=%0d, required addr=0x%04h bank=%0d",
                             addr, bank, e[15:0], e[18:16]);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Generator model: hold the tuple until await is low, then it is captured.
    task automatic send(input logic [7:0] ch, input logic [7:0] row, input logic [5:0] col,
                        input logic [2:0] bk, input logic [15:0] ea);
        idx_valid     = 1'b1;
        channel_index = ch;
        row_index     = row;
        col_index     = col;
        psum_index    = bk;
        for (int n = 0; n < 64; n++) begin
            if (!await) begin
                exp_q.push_back({bk, ea});
                tick();
                idx_valid = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got await=1 for 64 cycles, required release");
        idx_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int n = 0; n < 30; n++) begin
            if (exp_q.size() == 0 && !addr_valid) break;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic end_pass(input string name);
        int base;
        base = done_cnt;
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (done) break;
            tick();
        end
        tick();
        tick();
        chk({name, "_done_once"}, done_cnt - base, 1);
        chk({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int base;
        int pbase;
        reset         = 1'b1;
        base_addr     = 16'h0100;
        E             = 8'd4;
        F             = 6'd8;
        idx_valid     = 1'b0;
        psum_index    = '0;
        channel_index = '0;
        row_index     = '0;
        col_index     = '0;
        gen_done      = 1'b0;
        addr_ready    = 1'b0;
`ifdef PSUM_ADDR_CHECK_EN
        err_clr       = 1'b0;
`endif
        tick();
        tick();
        chk("rst_addr_valid", addr_valid, 0);
        chk("rst_await", await, 0);
        chk("rst_addr", addr, 0);
        chk("rst_bank", bank, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
`ifdef PSUM_ADDR_CHECK_EN
        chk("rst_err", err, 0);
`endif
        reset = 1'b0;
        tick();

        // Single address, latency and hold-after-empty
        send(8'd2, 8'd3, 6'd5, 3'd1, 16'h015D);
        chk("lat_edge1_valid", addr_valid, 0);
        chk("lat_busy_run", busy, 1);
        tick();
        chk("lat_edge2_valid", addr_valid, 0);
        tick();
        chk("lat_edge3_valid", addr_valid, 1);
        chk("lat_addr", addr, 16'h015D);
        chk("lat_bank", bank, 1);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        chk("hold_valid", addr_valid, 0);
        chk("hold_addr", addr, 16'h015D);
        chk("hold_bank", bank, 1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("pass1_done_early", done, 0);
        chk("pass1_busy_drain", busy, 1);
        tick();
        chk("pass1_done", done, 1);
        chk("pass1_busy_fall", busy, 0);
        tick();
        chk("pass1_done_width", done, 0);

        // Back-pressure with GLB stalled
        chk("bp_await0", await, 0);
        send(8'd0, 8'd0, 6'd0, 3'd0, 16'h0100);
        chk("bp_await1", await, 0);
        send(8'd0, 8'd0, 6'd1, 3'd1, 16'h0101);
        chk("bp_await2", await, 0);
        send(8'd0, 8'd1, 6'd0, 3'd2, 16'h0108);
        chk("bp_await3", await, 0);
        send(8'd1, 8'd0, 6'd0, 3'd3, 16'h0120);
        idx_valid     = 1'b1;
        channel_index = 8'd1;
        row_index     = 8'd2;
        col_index     = 6'd7;
        psum_index    = 3'd4;
        chk("bp_await_full", await, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_await_held", await, 1);
        chk("bp_valid_held", addr_valid, 1);
        addr_ready = 1'b1;
        send(8'd1, 8'd2, 6'd7, 3'd4, 16'h0137);
        send(8'd3, 8'd3, 6'd7, 3'd7, 16'h017F);
        wait_empty("bp_drained");
        end_pass("bp");

        // Streaming with GLB always ready
        pbase = pops;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stream_await_%0d", k), await, 0);
            if (k >= 3) chk($sformatf("stream_valid_%0d", k), addr_valid, 1);
            send(8'd0, 8'd0, 6'(k), 3'(k), 16'h0100 + 16'(k));
        end
        for (int i = 0; i < 4; i++) tick();
        chk("stream_pops", pops - pbase, 8);
        chk("stream_empty", exp_q.size(), 0);
        end_pass("stream");

        // Done sequencing with ready toggling in DRAIN
        addr_ready = 1'b0;
        send(8'd2, 8'd0, 6'd0, 3'd0, 16'h0140);
        send(8'd2, 8'd1, 6'd3, 3'd1, 16'h014B);
        send(8'd3, 8'd2, 6'd6, 3'd5, 16'h0176);
        tick();
        tick();
        tick();
        chk("ds_valid", addr_valid, 1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        base = done_cnt;
        chk("ds_busy_drain", busy, 1);
        addr_ready = 1'b1; tick();
        addr_ready = 1'b0; tick();
        addr_ready = 1'b1; tick();
        addr_ready = 1'b0; tick();
        chk("ds_no_early_done", done_cnt - base, 0);
        addr_ready = 1'b1; tick();
        addr_ready = 1'b0;
        chk("ds_last_pop_done", done, 0);
        chk("ds_last_pop_empty", addr_valid, 0);
        tick();
        chk("ds_done", done, 1);
        chk("ds_busy_fall", busy, 0);
        tick();
        chk("ds_done_width", done, 0);
        chk("ds_done_once", done_cnt - base, 1);
        chk("ds_queue_empty", exp_q.size(), 0);

        // Address wrap-around
        base_addr  = 16'hFFF0;
        addr_ready = 1'b1;
        send(8'd1, 8'd0, 6'd0, 3'd2, 16'h0010);
        wait_empty("wrap_drained");
        chk("wrap_hold_addr", addr, 16'h0010);
`ifdef PSUM_ADDR_CHECK_EN
        chk("wrap_err", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wrap_err_clr", err, 0);
`endif
        end_pass("wrap");
        base_addr = 16'h0100;

        // Reset in DRAIN discards queued addresses
        addr_ready = 1'b0;
        send(8'd0, 8'd2, 6'd1, 3'd3, 16'h0111);
        send(8'd0, 8'd2, 6'd2, 3'd4, 16'h0112);
        tick();
        tick();
        tick();
        chk("rd_valid_pre", addr_valid, 1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        base = done_cnt;
        reset = 1'b1;
        #1;
        chk("rd_valid", addr_valid, 0);
        chk("rd_await", await, 0);
        chk("rd_busy", busy, 0);
        chk("rd_addr", addr, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rd_no_done", done_cnt - base, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_valid", addr_valid, 0);
        // IDLE: an empty pass answers gen_done on the next edge
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("empty_pass_done", done, 1);
        chk("empty_pass_busy", busy, 0);
        tick();
        chk("empty_pass_width", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1);
    end

endmodule
